// File: rtl/fir_mac_engine.sv
// ---------------------------------------------------------------------------
// fir_mac_engine
//
// Streaming multiply-accumulate engine for FIR filtering. Each accepted term
// (x_in * tap_in) is added into a wide accumulator. After the last term of a
// frame the result is shifted, narrowed and held on y_out until the consumer
// takes it.
//
// Optional feature macro: FIR_MAC_SAT_EN
//   defined   : the shifted accumulator is clamped to the signed DATA_W range,
//               and sat_flag reports whether the current result was clipped.
//   undefined : the result wraps (two's complement), and sat_flag is tied 0.
//
// Parameters
//   DATA_W    signed width of sample, tap and result words
//   NUM_TAPS  maximum terms per frame (1..64)
//   OUT_SHIFT arithmetic right shift applied to the accumulator on output
//
// Ports
//   CLK       clock, all state on the rising edge
//   Resetn    asynchronous active-low reset
//   clear     synchronous frame abort, wins over any handshake that cycle
//   cfg_taps  terms per frame, sampled on the first term of a frame
//   in_valid  term offered            in_ready  term can be accepted
//   x_in      signed sample           tap_in    signed coefficient
//   y_out     signed result           y_valid   result held on y_out
//   y_ready   consumer takes result   busy      frame partially accumulated
//   sat_flag  current result was clipped
// ---------------------------------------------------------------------------
module fir_mac_engine #(
    parameter int DATA_W    = 32,
    parameter int NUM_TAPS  = 11,
    parameter int OUT_SHIFT = 0
) (
    input  logic                     CLK,
    input  logic                     Resetn,
    input  logic                     clear,
    input  logic [6:0]               cfg_taps,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic signed [DATA_W-1:0] tap_in,
    output logic signed [DATA_W-1:0] y_out,
    output logic                     y_valid,
    input  logic                     y_ready,
    output logic                     busy,
    output logic                     sat_flag
);

    // Headroom of clog2(NUM_TAPS) bits means a full frame can never overflow.
    localparam int ACC_W = 2 * DATA_W + $clog2(NUM_TAPS);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e                   state_q;
    logic [6:0]               cnt_q;
    logic [6:0]               taps_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [DATA_W-1:0] y_q;
    logic                     y_valid_q;

    logic                      accept;
    logic                      first_term;
    logic                      last_term;
    logic [6:0]                cfg_eff;
    logic [6:0]                taps_d;
    logic [6:0]                cnt_d;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   acc_d;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [DATA_W-1:0]  result_d;
    logic                      overflow;

    // A result waiting in HOLD blocks input; clear is applied on top of this
    // so a term offered in a clear cycle is dropped rather than accumulated.
    assign in_ready = !y_valid_q;
    assign accept   = in_valid && in_ready && !clear;
    assign busy     = (cnt_q != 7'd0);
    assign y_out    = y_q;
    assign y_valid  = y_valid_q;

    // Out-of-range tap counts (0 or above NUM_TAPS) fall back to NUM_TAPS.
    assign first_term = (cnt_q == 7'd0);
    assign cfg_eff    = (cfg_taps != 7'd0 && cfg_taps <= 7'(NUM_TAPS)) ? cfg_taps : 7'(NUM_TAPS);
    assign taps_d     = first_term ? cfg_eff : taps_q;
    assign cnt_d      = cnt_q + 7'd1;
    assign last_term  = (cnt_d == taps_d);

    // Operands are widened as signed values before the multiply so the full
    // 2*DATA_W product is formed, then sign-extended into the accumulator.
    assign prod     = (2*DATA_W)'(x_in) * (2*DATA_W)'(tap_in);
    assign prod_ext = ACC_W'(prod);
    assign acc_d    = first_term ? prod_ext : acc_q + prod_ext;
    assign shifted  = acc_d >>> OUT_SHIFT;

`ifdef FIR_MAC_SAT_EN
    // The value fits DATA_W only when every bit from DATA_W-1 upward equals
    // the sign bit; otherwise clamp to the extreme of matching sign.
    assign overflow = (shifted[ACC_W-1:DATA_W-1] != {(ACC_W-DATA_W+1){shifted[ACC_W-1]}});
    assign result_d = !overflow       ? shifted[DATA_W-1:0] :
                      shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} :
                                         {1'b0, {(DATA_W-1){1'b1}}};
    logic sat_q;
    assign sat_flag = sat_q;
`else
    logic unused_shift_bits;
    assign overflow          = 1'b0;
    assign result_d          = shifted[DATA_W-1:0];
    assign unused_shift_bits = ^{shifted[ACC_W-1:DATA_W], overflow};
    assign sat_flag          = 1'b0;
`endif

    // NOTE: all state uses non-blocking assignments so every register samples
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= ST_ACC;
            cnt_q     <= 7'd0;
            taps_q    <= 7'd0;
            acc_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
`ifdef FIR_MAC_SAT_EN
            sat_q     <= 1'b0;
`endif
        end else if (clear) begin
            state_q   <= ST_ACC;
            cnt_q     <= 7'd0;
            acc_q     <= '0;
            y_valid_q <= 1'b0;
`ifdef FIR_MAC_SAT_EN
            sat_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (accept) begin
                        acc_q  <= acc_d;
                        taps_q <= taps_d;
                        if (last_term) begin
                            cnt_q     <= 7'd0;
                            y_q       <= result_d;
                            y_valid_q <= 1'b1;
                            state_q   <= ST_HOLD;
`ifdef FIR_MAC_SAT_EN
                            sat_q     <= overflow;
`endif
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                ST_HOLD: begin
                    if (y_ready) begin
                        y_valid_q <= 1'b0;
                        state_q   <= ST_ACC;
                    end
                end
                default: begin
                    state_q   <= ST_ACC;
                    y_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fir_mac_engine.md
FIR_MAC_ENGINE -- requirements
Module: fir_mac_engine

Interface
REQ-001 Parameter DATA_W, default 32, signed width of sample, tap and result words.
REQ-002 Parameter NUM_TAPS, default 11, maximum terms per output (legal range 1..64).
REQ-003 Parameter OUT_SHIFT, default 0, arithmetic right shift applied to the accumulator before output.
REQ-004 Port CLK  input  1  sole clock, all state on rising edge.
REQ-005 Port Resetn  input  1  reset, asynchronous and active-low.
REQ-006 Port clear  input  1  synchronous frame abort.
REQ-007 Port cfg_taps  input  7  terms per frame, sampled at first term of a frame.
REQ-008 Port in_valid  input  1  term offered.
REQ-009 Port in_ready  output  1  term can be accepted.
REQ-010 Port x_in  input  DATA_W  signed sample.
REQ-011 Port tap_in  input  DATA_W  signed coefficient.
REQ-012 Port y_out  output  DATA_W  signed filter result.
REQ-013 Port y_valid  output  1  result held on y_out.
REQ-014 Port y_ready  input  1  consumer accepts result.
REQ-015 Port busy  output  1  frame partially accumulated (term count nonzero).
REQ-016 Port sat_flag  output  1  last result clipped (always 0 without FIR_MAC_SAT_EN).

Function
REQ-017 Term accepted when in_valid and in_ready are both high on a rising edge; in_ready = not y_valid.
REQ-018 Product = signed x_in * signed tap_in, 2*DATA_W bits, sign-extended into accumulator of 2*DATA_W + clog2(NUM_TAPS) bits; no overflow possible inside a frame.
REQ-019 First accepted term of a frame loads accumulator with the product; later terms add the product.
REQ-020 Effective tap count latched at first term: cfg_taps if in 1..NUM_TAPS, else NUM_TAPS; changes to cfg_taps mid-frame are ignored.
REQ-021 States ACC and HOLD; ACC -> HOLD on acceptance of the last term, HOLD -> ACC when y_ready is high.
REQ-022 On entry to HOLD: y_out registered from final sum, y_valid high the cycle after the last-term handshake (latency 1 cycle).
REQ-023 In HOLD y_out and y_valid stay stable until y_ready; no term accepted during HOLD, including the y_ready cycle.
REQ-024 Term counter returns to 0 on last-term acceptance; busy low in HOLD.
REQ-025 Single-tap frame (effective count 1): product alone forms the result.
REQ-026 Without saturation, y_out = low DATA_W bits of (accumulator >>> OUT_SHIFT), two's-complement wrap.
REQ-027 clear high: counter 0, accumulator 0, y_valid 0, state ACC, sat_flag 0; clear overrides any simultaneous handshake, and the term offered that cycle is dropped.
REQ-028 in_valid low in ACC: accumulator and counter hold (gaps between terms allowed).

Reset
REQ-029 Resetn low asynchronously forces state ACC, counter 0, accumulator 0, y_out 0, y_valid 0, sat_flag 0, in_ready 1 after reset, busy 0.
REQ-030 Reset mid-frame or in HOLD discards partial sum and pending result; first term after release starts a new frame.

Configuration
REQ-031 Macro FIR_MAC_SAT_EN defined: shifted accumulator clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1], sat_flag set with the result when clamping occurs, cleared with next result.
REQ-032 Macro FIR_MAC_SAT_EN undefined: wrap per REQ-026, sat_flag tied 0, no clamp logic synthesised.

Verification
REQ-033 Defaults, cfg_taps=11, x_in=1..11, tap_in=2 every cycle, y_ready=1 -> y_out=132, y_valid one cycle after 11th term, single-cycle pulse.
REQ-034 cfg_taps=3, x=-5,7,4, tap=3,-2,10 with in_valid gaps, y_ready low 5 cycles -> y_out=11 held stable 5+ cycles, in_ready low throughout.
REQ-035 cfg_taps=0 and cfg_taps=100 -> each frame takes 11 terms; cfg_taps changed to 2 after term 1 -> still 11 terms.
REQ-036 clear asserted with in_valid after 4 terms -> busy 0 next cycle, next 11 terms (x=1,tap=1) give y_out=11.
REQ-037 DATA_W=8, cfg_taps=2, x=127,127, tap=127,127 -> with FIR_MAC_SAT_EN y_out=127, sat_flag=1; without y_out=2 (32258 mod 256), sat_flag=0.
REQ-038 Resetn pulsed low mid-frame and in HOLD -> all outputs 0 immediately, in_ready 1, following frame correct.
